// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared definitions for the pipelined adder/subtractor.
//   - OP_ADD / OP_SUB : encoding of the sub_i operation select.
//   - stages_legal()  : true when WIDTH splits evenly into STAGES chunks.
//   - chunk_width()   : width of one per-stage chunk, safe against STAGES=0 so
//                       the legality check can report instead of dividing by 0.
//   - PIPE_ADDER_CHECK(W, S) : generate-scope macro that stops elaboration on an
//                       illegal WIDTH/STAGES combination.
// -----------------------------------------------------------------------------
`ifndef PIPE_ADDER_CHECK
`define PIPE_ADDER_CHECK(W, S) \
  if (!pipe_adder_pkg::stages_legal((W), (S))) begin : g_param_check \
    $error("pipe_adder: STAGES must be in 1..WIDTH and divide WIDTH evenly"); \
  end
`endif

package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit stages_legal(input int unsigned width, input int unsigned stages);
    if (stages < 1) return 1'b0;
    if (stages > width) return 1'b0;
    return (width % stages) == 0;
  endfunction

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    if (stages == 0) return width;
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational CW-bit ripple slice used once per pipeline stage.
//   Ports:
//     a, b      in  CW  chunk operands (b already inverted for subtract)
//     cin       in  1   carry from the previous chunk
//     s         out CW  chunk sum
//     cout      out 1   carry out of the chunk MSB
//     c_msb_in  out 1   carry into the chunk MSB (for signed overflow)
// -----------------------------------------------------------------------------
module adder_slice #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  if (CW == 1) begin : g_bit
    // Single-bit chunk: the carry into the MSB is the chunk carry-in itself.
    assign c_msb_in = cin;
    assign s        = a ^ b ^ cin;
    assign cout     = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  end else begin : g_wide
    // Add the low CW-1 bits in a CW-bit result so the top bit is the carry into
    // the MSB; the MSB is then finished explicitly to expose that carry.
    logic [CW-1:0] low;
    logic          msb_p;

    assign low      = {1'b0, a[CW-2:0]} + {1'b0, b[CW-2:0]} + {{(CW-1){1'b0}}, cin};
    assign c_msb_in = low[CW-1];
    assign msb_p    = a[CW-1] ^ b[CW-1];
    assign s        = {msb_p ^ low[CW-1], low[CW-2:0]};
    assign cout     = (a[CW-1] & b[CW-1]) | (msb_p & low[CW-1]);
  end

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined WIDTH-bit add/subtract. The operation is split into STAGES chunks
//   of CW bits; stage k adds chunk k and registers it together with the carry,
//   the lower sum chunks already produced and the operands still to be added.
//   Latency is STAGES cycles, throughput one result per cycle. A single global
//   enable freezes the whole pipe when the output is held.
//   Ports:
//     clk_i    in  1      clock, rising edge
//     rst_i    in  1      asynchronous reset, active high
//     valid_i  in  1      operands valid
//     ready_o  out 1      operands accepted this cycle when valid_i is high
//     src1_i   in  WIDTH  operand A
//     src2_i   in  WIDTH  operand B
//     sub_i    in  1      OP_ADD: A+B, OP_SUB: A-B
//     valid_o  out 1      result valid
//     ready_i  in  1      downstream accepts result
//     sum_o    out WIDTH  result modulo 2^WIDTH
//     cout_o   out 1      carry out of MSB (subtract: 1 = no borrow)
//     ovf_o    out 1      signed two's-complement overflow
//     zero_o   out 1      result is zero (only asserted with valid_o)
// -----------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

  `PIPE_ADDER_CHECK(WIDTH, STAGES)

  // Stage registers, index k = pipeline stage.
  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0]            carry_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic                         c_msb_q;

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1.
  logic [STAGES-1:0]            in_v;
  logic [STAGES-1:0]            in_c;
  logic [STAGES-1:0][WIDTH-1:0] in_a;
  logic [STAGES-1:0][WIDTH-1:0] in_b;
  logic [STAGES-1:0][WIDTH-1:0] in_s;

  // Slice results and next-state sums.
  logic [STAGES-1:0][CW-1:0]    sl_s;
  logic [STAGES-1:0]            sl_cout;
  logic [STAGES-1:0]            sl_cmsb;
  logic [STAGES-1:0][WIDTH-1:0] sum_d;

  logic             en;
  logic [WIDTH-1:0] b_eff;

  // Subtract as A + ~B + 1: invert B here, the +1 enters as the stage-0 carry.
  assign b_eff = (sub_i == OP_SUB) ? ~src2_i : src2_i;

  always_comb begin
    in_v    = '0;
    in_c    = '0;
    in_a    = '0;
    in_b    = '0;
    in_s    = '0;
    in_v[0] = valid_i;
    in_c[0] = sub_i;
    in_a[0] = src1_i;
    in_b[0] = b_eff;
    for (int k = 1; k < STAGES; k++) begin
      in_v[k] = vld_q[k-1];
      in_c[k] = carry_q[k-1];
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(
      .CW (CW)
    ) u_slice (
      .a        (in_a[k][k*CW +: CW]),
      .b        (in_b[k][k*CW +: CW]),
      .cin      (in_c[k]),
      .s        (sl_s[k]),
      .cout     (sl_cout[k]),
      .c_msb_in (sl_cmsb[k])
    );
  end

  // Each stage passes the lower sum chunks through and inserts its own chunk.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]              = in_s[k];
      sum_d[k][k*CW +: CW]  = sl_s[k];
    end
  end

  // Whole pipe advances together; a held output stalls every stage.
  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_msb_q <= 1'b0;
    end else if (en) begin
      vld_q   <= in_v;
      carry_q <= sl_cout;
      a_q     <= in_a;
      b_q     <= in_b;
      sum_q   <= sum_d;
      c_msb_q <= sl_cmsb[STAGES-1];
    end
  end

  assign valid_o = vld_q[STAGES-1];
  assign sum_o   = sum_q[STAGES-1];
  assign cout_o  = carry_q[STAGES-1];
  assign ovf_o   = c_msb_q ^ carry_q[STAGES-1];
  // Gated with valid so an idle/reset pipe does not report a zero result.
  assign zero_o  = valid_o & ~|sum_o;

  // Already-consumed operand chunks and lower-slice MSB carries have no reader.
  logic unused_bits;
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], in_a, in_b, sl_cmsb};

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the CPU's 32-bit combinational adder; supports add and subtract.
- Splits a WIDTH-bit operation into STAGES carry-chained chunks, one chunk per register stage, to cut the critical path for deeper CPU pipelines and ALU reuse.
- Provides valid/ready handshakes on input and output, plus carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, number of pipeline stages = latency in cycles. Legal when 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0; otherwise elaboration error.
- CW, WIDTH/STAGES, derived chunk width (localparam, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block accepts input this cycle.
- src1_i  in  WIDTH  operand A.
- src2_i  in  WIDTH  operand B.
- sub_i  in  1  0 = A+B, 1 = A-B.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- sum_o  out  WIDTH  result, modulo 2^WIDTH.
- cout_o  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf_o  out  1  signed two's-complement overflow.
- zero_o  out  1  sum_o == 0.

Behaviour:
- Reset (rst_i high, async): all stage valid bits, carry regs and data regs clear to 0. Outputs valid_o=0, sum_o=0, cout_o=0, ovf_o=0, zero_o=0. ready_o=1 combinationally once reset is deasserted.
- Reset mid-operation: in-flight items are discarded; nothing is emitted afterwards.
- Global advance enable: en = !valid_o || ready_i. ready_o = en.
- All stage registers load only when en=1. Bubbles are not collapsed; a stall freezes the whole pipe.
- Input transfer occurs when valid_i && ready_o. Output transfer occurs when valid_o && ready_i.
- Stage 0 captures the operands, sub_i and valid_i, with B' = sub ? ~B : B and cin = sub.
- Stage k (0..STAGES-1) adds chunk k of A and B' plus the carry from stage k-1 (cin at stage 0).
  - Registers the CW-bit partial sum and the carry.
  - Forwards undelayed higher chunks and the already-computed lower sum chunks (skew registers).
- The final stage also records the carry into the MSB. ovf = c_into_msb XOR c_out_msb.
- zero_o is derived from the registered sum_o (combinational OR-reduce is allowed).
- Latency: a transfer accepted at edge t produces valid_o after edge t+STAGES when not stalled. Throughput is 1 result/cycle.
- Held output: while valid_o && !ready_i, sum_o and the flags stay stable, and valid_o stays high.
- Ordering: results leave in acceptance order; exactly one output per accepted input.
- Simultaneous accept and emit in the same cycle is legal and required at full throughput.
- valid_i=0 while ready_o=1 inserts a bubble, which propagates as valid=0.
- STAGES=1 degenerates to a single registered full-width adder with the same handshake.
- Arithmetic:
  - sum wraps modulo 2^WIDTH.
  - A-B is computed as A + ~B + 1.
  - Subtract with B=0 gives cout=1.

Decomposition:
- Shared package/header: op constants OP_ADD=1'b0 and OP_SUB=1'b1; a compile-time check macro for WIDTH % STAGES.
- One sub-module, adder_slice: parameter CW; inputs a, b, cin; outputs s, cout, c_msb_in (carry into the slice MSB).
  - Instantiated STAGES times in a generate loop.
  - Only the top slice's c_msb_in is used.

Test Plan (WIDTH=32, STAGES=4 unless noted):
1. Basic add and latency: single item A=0x0000_0001, B=0x0000_0002, add, ready_i=1 -> valid_o exactly 4 cycles after accept; sum=0x0000_0003; cout=0, ovf=0, zero=0.
2. Cross-chunk carry, overflow and zero:
   - A=0xFFFF_FFFF, B=1, add -> sum=0, cout=1, ovf=0, zero=1.
   - A=0x7FFF_FFFF, B=1 -> sum=0x8000_0000, ovf=1, cout=0.
3. Subtract:
   - A=5, B=7, sub -> sum=0xFFFF_FFFE, cout=0, ovf=0.
   - A=0x8000_0000, B=1, sub -> sum=0x7FFF_FFFF, ovf=1, cout=1.
4. Back-pressure: stream 8 random pairs back-to-back; hold ready_i=0 for 5 cycles mid-stream ->
   - ready_o low throughout the stall;
   - sum_o stable while held;
   - all 8 results correct, in order, none duplicated or lost;
   - full throughput resumes after the stall.
5. Reset mid-flight: accept 3 items, assert rst_i asynchronously between edges -> valid_o=0 and sum_o=0 immediately; no result emitted after release; a new item then has 4-cycle latency.
6. Parameter sweep with random add/sub versus a reference model:
   - STAGES=1 -> latency 1 with identical results;
   - WIDTH=8, STAGES=8 -> latency 8, correct results.
